// File: rtl/fifo_ctrl_ext_pkg.sv
// fifo_pkg: shared types and helpers for the fifo_ctrl_ext controller.
//   fifo_op_e : decodes {wr_ok, rd_ok} into the operation performed this cycle.
//   wrap_inc  : modulo-depth pointer increment that works for any depth, not only powers of two.
package fifo_pkg;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_RD   = 2'b01,
        FIFO_WR   = 2'b10,
        FIFO_RW   = 2'b11
    } fifo_op_e;

    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ctrl_ext_if.sv
// fifo_ctrl_ext_if: handshake/status bundle between a FIFO user and the fifo_ctrl_ext controller.
//   master : the user side; drives rd, wr, err_clr and observes addresses, strobe and status.
//   slave  : the controller side.
//   rd/wr/err_clr        requests and sticky-error clear
//   w_addr/r_addr/w_en   RAM write/read address and write strobe
//   empty/full/almost_*  registered status; count is occupancy 0..DEPTH
//   overflow/underflow   sticky refused-request flags (0 unless FIFO_ERR_FLAGS_EN)
interface fifo_ctrl_ext_if #(
    parameter int unsigned DEPTH = 6
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          rd;
    logic          wr;
    logic          err_clr;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          w_en;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output rd, wr, err_clr,
        input  w_addr, r_addr, w_en, empty, full, almost_empty, almost_full, count,
        input  overflow, underflow
    );

    modport slave (
        input  rd, wr, err_clr,
        output w_addr, r_addr, w_en, empty, full, almost_empty, almost_full, count,
        output overflow, underflow
    );

endinterface

// File: rtl/fifo_ctrl_ext_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer register; used once for the write and once for the read side.
//   clk     rising-edge clock
//   reset_n asynchronous active-low reset (pointer -> 0)
//   inc     advance pointer on this edge
//   ptr     current pointer value 0..DEPTH-1
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = AW'(wrap_inc(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl_ext.sv
// fifo_ctrl_ext: address/status controller for a FIFO held in an external dual-port RAM.
// Any DEPTH >= 2; keeps an occupancy count and registered empty/full/almost_* flags.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      fifo_ctrl_ext_if.slave: rd, wr, err_clr in; w_addr, r_addr, w_en, status, count,
//            overflow, underflow out
// Build option: define FIFO_ERR_FLAGS_EN to get sticky overflow/underflow flags cleared by
// err_clr; otherwise both are tied to 0 and err_clr is ignored.
module fifo_ctrl_ext
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 6,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    fifo_ctrl_ext_if.slave  bus
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;

    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0] AfLevel  = CntW'(AF_LEVEL);
    localparam logic [CntW-1:0] AeLevel  = CntW'(AE_LEVEL);

    logic            rd_ok, wr_ok;
    fifo_op_e        op;
    logic [AW-1:0]   w_ptr, r_ptr;

    logic [CntW-1:0] count_q, count_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            almost_empty_q, almost_empty_d;
    logic            almost_full_q, almost_full_d;

    // Acceptance from registered state only. At full a simultaneous read frees the slot the
    // write reuses; at empty the read is refused so only the write happens.
    always_comb begin
        rd_ok = bus.rd & ~empty_q;
        wr_ok = bus.wr & (~full_q | rd_ok);
        op    = fifo_op_e'({wr_ok, rd_ok});
    end

    // Flags derive from count_d so they change on the same edge as the pointers.
    always_comb begin
        count_d = count_q;
        unique case (op)
            FIFO_WR:            count_d = count_q + CntW'(1);
            FIFO_RD:            count_d = count_q - CntW'(1);
            FIFO_IDLE, FIFO_RW: count_d = count_q;
        endcase
        empty_d        = (count_d == '0);
        full_d         = (count_d == DepthCnt);
        almost_empty_d = (count_d <= AeLevel);
        almost_full_d  = (count_d >= AfLevel);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
        end else begin
            count_q        <= count_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
        end
    end

    fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_w_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wr_ok),
        .ptr     (w_ptr)
    );

    fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_r_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (rd_ok),
        .ptr     (r_ptr)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new refusal in the same cycle as err_clr keeps the flag set.
    always_comb begin
        overflow_d  = (bus.wr & ~wr_ok) | (overflow_q & ~bus.err_clr);
        underflow_d = (bus.rd & ~rd_ok) | (underflow_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

    assign bus.w_addr       = w_ptr;
    assign bus.r_addr       = r_ptr;
    assign bus.w_en         = wr_ok;
    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.almost_full  = almost_full_q;

endmodule

// File: tb/tb_fifo_ctrl_ext.sv
// tb_fifo_ctrl_ext: directed self-checking bench for fifo_ctrl_ext at DEPTH=6, AF=5, AE=1.
// Expected values are hand-derived; overflow/underflow expectations follow FIFO_ERR_FLAGS_EN.
module tb_fifo_ctrl_ext;

    logic clk = 1'b0;
    logic reset_n;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    fifo_ctrl_ext_if #(.DEPTH(6)) bus ();

    fifo_ctrl_ext #(
        .DEPTH    (6),
        .AF_LEVEL (5),
        .AE_LEVEL (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " count"},        32'(bus.count),        32'd0);
        chk({tag, " empty"},        32'(bus.empty),        32'd1);
        chk({tag, " almost_empty"}, 32'(bus.almost_empty), 32'd1);
        chk({tag, " full"},         32'(bus.full),         32'd0);
        chk({tag, " almost_full"},  32'(bus.almost_full),  32'd0);
        chk({tag, " w_addr"},       32'(bus.w_addr),       32'd0);
        chk({tag, " r_addr"},       32'(bus.r_addr),       32'd0);
        chk({tag, " overflow"},     32'(bus.overflow),     32'd0);
        chk({tag, " underflow"},    32'(bus.underflow),    32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.err_clr = 1'b0;
        #12;
        reset_n = 1'b1;
        chk_reset("por");
        tick();
        chk("idle count", 32'(bus.count), 32'd0);

        // Two writes, then an asynchronous reset between clock edges.
        bus.wr = 1'b1;
        tick();
        tick();
        chk("pre-reset count",  32'(bus.count),  32'd2);
        chk("pre-reset w_addr", 32'(bus.w_addr), 32'd2);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset("async");
        bus.wr = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();

        // Fill: count 1..6, watermarks and w_addr 0..5 then wrap to 0.
        for (int i = 0; i < 6; i++) begin
            bus.wr = 1'b1;
            #1;
            chk("fill w_en",   32'(bus.w_en),   32'd1);
            chk("fill w_addr", 32'(bus.w_addr), 32'(i));
            tick();
            chk("fill count",        32'(bus.count),        32'(i + 1));
            chk("fill empty",        32'(bus.empty),        32'd0);
            chk("fill almost_empty", 32'(bus.almost_empty), 32'((i + 1) <= 1));
            chk("fill almost_full",  32'(bus.almost_full),  32'((i + 1) >= 5));
            chk("fill full",         32'(bus.full),         32'((i + 1) == 6));
        end
        chk("fill wrap w_addr", 32'(bus.w_addr), 32'd0);

        // Overfill: write refused.
        #1;
        chk("overfill w_en", 32'(bus.w_en), 32'd0);
        tick();
        chk("overfill count",  32'(bus.count),  32'd6);
        chk("overfill w_addr", 32'(bus.w_addr), 32'd0);
        chk("overfill full",   32'(bus.full),   32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow set", 32'(bus.overflow), 32'd1);
        bus.wr = 1'b0;
        tick();
        chk("overflow sticky", 32'(bus.overflow), 32'd1);
        bus.err_clr = 1'b1;
        bus.wr      = 1'b1;
        tick();
        chk("overflow set beats clr", 32'(bus.overflow), 32'd1);
        bus.wr = 1'b0;
        tick();
        chk("overflow cleared", 32'(bus.overflow), 32'd0);
        bus.err_clr = 1'b0;
`else
        chk("overflow tied", 32'(bus.overflow), 32'd0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
`endif

        // rd & wr at full: both accepted.
        bus.rd = 1'b1;
        bus.wr = 1'b1;
        #1;
        chk("rw full w_en", 32'(bus.w_en), 32'd1);
        tick();
        chk("rw full count",  32'(bus.count),  32'd6);
        chk("rw full full",   32'(bus.full),   32'd1);
        chk("rw full w_addr", 32'(bus.w_addr), 32'd1);
        chk("rw full r_addr", 32'(bus.r_addr), 32'd1);
        bus.rd = 1'b0;
        bus.wr = 1'b0;

        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("reset2");
        reset_n = 1'b1;
        tick();

        // rd & wr at empty: write only.
        bus.rd = 1'b1;
        bus.wr = 1'b1;
        #1;
        chk("rw empty w_en", 32'(bus.w_en), 32'd1);
        tick();
        chk("rw empty count",  32'(bus.count),  32'd1);
        chk("rw empty empty",  32'(bus.empty),  32'd0);
        chk("rw empty r_addr", 32'(bus.r_addr), 32'd0);
        chk("rw empty w_addr", 32'(bus.w_addr), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("underflow set", 32'(bus.underflow), 32'd1);
`else
        chk("underflow tied", 32'(bus.underflow), 32'd0);
`endif
        bus.rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        bus.wr = 1'b0;
        chk("refill count",  32'(bus.count),  32'd6);
        chk("refill w_addr", 32'(bus.w_addr), 32'd0);
        chk("refill full",   32'(bus.full),   32'd1);

        // Drain: r_addr 0..5 then wraps to 0.
        bus.rd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("drain r_addr", 32'(bus.r_addr), 32'(i));
            tick();
            chk("drain count", 32'(bus.count), 32'(5 - i));
            chk("drain empty", 32'(bus.empty), 32'(i == 5));
        end
        chk("drain wrap r_addr", 32'(bus.r_addr), 32'd0);

        // Extra read on empty: refused.
        tick();
        chk("extra rd r_addr", 32'(bus.r_addr), 32'd0);
        chk("extra rd w_addr", 32'(bus.w_addr), 32'd0);
        chk("extra rd count",  32'(bus.count),  32'd0);
        chk("extra rd empty",  32'(bus.empty),  32'd1);
        bus.rd = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
